// File: rtl/fetch_timing_if.sv
// Timing-unit bus: decoder-side controls in, T-state vector and fetch strobes out.
interface fetch_timing_if #(
  parameter int T_STATES = 8,
  parameter int TW       = 4,
  parameter int BW       = 2,
  parameter int ICW      = 16
);
  logic                Stall;
  logic                SC_Clear;
  logic [T_STATES-1:0] Timing;
  logic [TW-1:0]       TCount;
  logic                Fetch;
  logic                Exec;
  logic                Mem_Read;
  logic                IR_Load;
  logic [BW-1:0]       IR_Beat;
  logic                PC_Inc;
  logic                Overrun;
  logic [ICW-1:0]      Inst_Count;

  // The timing unit drives the state outputs; the decoder drives Stall/SC_Clear.
  modport master (
    input  Stall, SC_Clear,
    output Timing, TCount, Fetch, Exec, Mem_Read, IR_Load, IR_Beat, PC_Inc,
           Overrun, Inst_Count
  );

  modport slave (
    output Stall, SC_Clear,
    input  Timing, TCount, Fetch, Exec, Mem_Read, IR_Load, IR_Beat, PC_Inc,
           Overrun, Inst_Count
  );
endinterface

// File: rtl/fetch_timing_unit.sv
// T-state sequencer for the multi-cycle CPU: multi-beat IR fetch, execute states
// held until end-of-instruction, stall, sticky overrun and retired-instruction count.
module fetch_timing_unit #(
  parameter int T_STATES    = 8,
  parameter int FETCH_BEATS = 2,
  parameter int TW          = 4,
  parameter int BW          = 2,
  parameter int ICW         = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  fetch_timing_if.master bus
);

  if (FETCH_BEATS < 1 || FETCH_BEATS > 4 ||
      T_STATES < FETCH_BEATS + 1 || T_STATES > 16 ||
      (1 << TW) < T_STATES || (1 << BW) < FETCH_BEATS) begin : g_param_check
    $error("fetch_timing_unit: illegal parameter combination");
  end

  localparam logic [TW-1:0] LAST_T = TW'(T_STATES - 1);
  localparam logic [TW-1:0] NBEATS = TW'(FETCH_BEATS);

  logic [TW-1:0]       tcount_q, tcount_d;
  logic [T_STATES-1:0] timing_q, timing_d;
  logic                overrun_q, overrun_d;
  logic [ICW-1:0]      icount_q, icount_d;
  logic                fetch;

  assign fetch = (tcount_q < NBEATS);

  // Priority below Reset: Stall, then fetch-always-advances, then SC_Clear, then advance/wrap.
  always_comb begin
    tcount_d  = tcount_q;
    overrun_d = overrun_q;
    icount_d  = icount_q;
    if (!bus.Stall) begin
      if (fetch) begin
        tcount_d = tcount_q + TW'(1);
      end else if (bus.SC_Clear) begin
        tcount_d = '0;
        icount_d = icount_q + ICW'(1);
      end else if (tcount_q == LAST_T) begin
        tcount_d  = '0;
        overrun_d = 1'b1;
      end else begin
        tcount_d = tcount_q + TW'(1);
      end
    end
  end

  // One-hot is registered from the next count so it is glitch-free and aligned with TCount.
  always_comb begin
    timing_d = '0;
    for (int k = 0; k < T_STATES; k++) begin
      timing_d[k] = (tcount_d == TW'(k));
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      tcount_q  <= '0;
      timing_q  <= T_STATES'(1);
      overrun_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      tcount_q  <= tcount_d;
      timing_q  <= timing_d;
      overrun_q <= overrun_d;
      icount_q  <= icount_d;
    end
  end

  assign bus.Timing     = timing_q;
  assign bus.TCount     = tcount_q;
  assign bus.Fetch      = fetch;
  assign bus.Exec       = ~fetch;
  assign bus.Mem_Read   = fetch & ~bus.Stall;
  assign bus.IR_Load    = fetch & ~bus.Stall;
  assign bus.PC_Inc     = fetch & ~bus.Stall;
  assign bus.IR_Beat    = fetch ? BW'(tcount_q) : '0;
  assign bus.Overrun    = overrun_q;
  assign bus.Inst_Count = icount_q;

endmodule

// File: tb/tb_fetch_timing_unit.sv
// Bench for fetch_timing_unit: default build (a) and a T_STATES=4/FETCH_BEATS=1/ICW=3 build (b).
module tb_fetch_timing_unit;

  logic Clock;
  logic rst_a, rst_b;
  int   checks, failures;

  fetch_timing_if #(.T_STATES(8), .TW(4), .BW(2), .ICW(16)) ifa ();
  fetch_timing_if #(.T_STATES(4), .TW(4), .BW(2), .ICW(3))  ifb ();

  fetch_timing_unit #(.T_STATES(8), .FETCH_BEATS(2), .TW(4), .BW(2), .ICW(16)) dut_a (
    .Clock(Clock), .Reset(rst_a), .bus(ifa));
  fetch_timing_unit #(.T_STATES(4), .FETCH_BEATS(1), .TW(4), .BW(2), .ICW(3)) dut_b (
    .Clock(Clock), .Reset(rst_b), .bus(ifb));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model state: current T-state, sticky overrun, retired count, and the applied inputs.
  int ma_t, ma_cnt, mb_t, mb_cnt;
  bit ma_ov, mb_ov;
  bit sa_st, sa_sc, sa_rn, sb_st, sb_sc, sb_rn;

  function automatic void adv(input int T, input int FB, input int W,
                              input bit st, input bit sc, input bit rn,
                              inout int t, inout int cnt, inout bit ov);
    if (!rn) begin
      t = 0; cnt = 0; ov = 0;
    end else if (!st) begin
      if (t < FB) t = t + 1;
      else if (sc) begin t = 0; cnt = (cnt + 1) % (1 << W); end
      else if (t == T - 1) begin t = 0; ov = 1; end
      else t = t + 1;
    end
  endfunction

  function automatic void adv_a();
    adv(8, 2, 16, sa_st, sa_sc, sa_rn, ma_t, ma_cnt, ma_ov);
  endfunction

  function automatic void adv_b();
    adv(4, 1, 3, sb_st, sb_sc, sb_rn, mb_t, mb_cnt, mb_ov);
  endfunction

  function automatic logic [63:0] exp_a();
    logic [7:0] tim; logic f, s; logic [1:0] beat;
    tim  = 8'(1 << ma_t);
    f    = (ma_t < 2);
    s    = f & ~sa_st;
    beat = f ? 2'(ma_t) : 2'd0;
    return 64'({tim, 4'(ma_t), f, ~f, s, s, beat, s, ma_ov, 16'(ma_cnt)});
  endfunction

  function automatic logic [63:0] obs_a();
    return 64'({ifa.Timing, ifa.TCount, ifa.Fetch, ifa.Exec, ifa.Mem_Read, ifa.IR_Load,
                ifa.IR_Beat, ifa.PC_Inc, ifa.Overrun, ifa.Inst_Count});
  endfunction

  function automatic logic [63:0] exp_b();
    logic [3:0] tim; logic f, s;
    tim = 4'(1 << mb_t);
    f   = (mb_t < 1);
    s   = f & ~sb_st;
    return 64'({tim, 4'(mb_t), f, ~f, s, s, 2'd0, s, mb_ov, 3'(mb_cnt)});
  endfunction

  function automatic logic [63:0] obs_b();
    return 64'({ifb.Timing, ifb.TCount, ifb.Fetch, ifb.Exec, ifb.Mem_Read, ifb.IR_Load,
                ifb.IR_Beat, ifb.PC_Inc, ifb.Overrun, ifb.Inst_Count});
  endfunction

  task automatic step_a(input bit st, input bit sc, input bit rn);
    @(negedge Clock);
    sa_st = st; sa_sc = sc; sa_rn = rn;
    ifa.Stall = st; ifa.SC_Clear = sc; rst_a = rn;
    #1;
  endtask

  task automatic step_b(input bit st, input bit sc, input bit rn);
    @(negedge Clock);
    sb_st = st; sb_sc = sc; sb_rn = rn;
    ifb.Stall = st; ifb.SC_Clear = sc; rst_b = rn;
    #1;
  endtask

  task automatic test_reset();
    step_a(0, 0, 0); adv_a();
    step_a(0, 0, 0); adv_a();
    step_a(0, 0, 1);
    checks++; if (ifa.TCount !== 4'd0) begin failures++; $display("FAIL reset_tcount got=%0d exp=0", ifa.TCount); end
    checks++; if (ifa.Timing !== 8'd1) begin failures++; $display("FAIL reset_timing got=%h exp=01", ifa.Timing); end
    checks++; if (ifa.Overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", ifa.Overrun); end
    checks++; if (ifa.Inst_Count !== 16'd0) begin failures++; $display("FAIL reset_icount got=%0d exp=0", ifa.Inst_Count); end
    checks++; if (ifa.Mem_Read !== 1'b1) begin failures++; $display("FAIL reset_memread got=%b exp=1", ifa.Mem_Read); end
    checks++; if (obs_a() !== exp_a()) begin failures++; $display("FAIL reset_vec got=%h exp=%h", obs_a(), exp_a()); end
    adv_a();
  endtask

  task automatic test_free_run();
    step_a(0, 0, 0); adv_a();
    for (int i = 0; i < 18; i++) begin
      step_a(0, 0, 1);
      checks++; if (obs_a() !== exp_a()) begin failures++; $display("FAIL free_vec cyc=%0d got=%h exp=%h", i, obs_a(), exp_a()); end
      checks++; if (ifa.Timing !== 8'(1 << (i % 8))) begin failures++; $display("FAIL free_timing cyc=%0d got=%h exp=%h", i, ifa.Timing, 8'(1 << (i % 8))); end
      checks++; if (ifa.PC_Inc !== ((i % 8) < 2)) begin failures++; $display("FAIL free_pcinc cyc=%0d got=%b", i, ifa.PC_Inc); end
      checks++; if (ifa.Overrun !== (i >= 8)) begin failures++; $display("FAIL free_overrun cyc=%0d got=%b", i, ifa.Overrun); end
      checks++; if (ifa.Inst_Count !== 16'd0) begin failures++; $display("FAIL free_icount cyc=%0d got=%0d exp=0", i, ifa.Inst_Count); end
      adv_a();
    end
  endtask

  task automatic test_sc_pulse();
    step_a(0, 0, 0); adv_a();
    for (int i = 0; i < 15; i++) begin
      step_a(0, (i % 3) == 2, 1);
      checks++; if (obs_a() !== exp_a()) begin failures++; $display("FAIL pulse_vec cyc=%0d got=%h exp=%h", i, obs_a(), exp_a()); end
      checks++; if (ifa.TCount !== 4'(i % 3)) begin failures++; $display("FAIL pulse_period cyc=%0d got=%0d exp=%0d", i, ifa.TCount, i % 3); end
      adv_a();
    end
    step_a(0, 0, 1);
    checks++; if (ifa.Inst_Count !== 16'd5) begin failures++; $display("FAIL pulse_icount got=%0d exp=5", ifa.Inst_Count); end
    checks++; if (ifa.Overrun !== 1'b0) begin failures++; $display("FAIL pulse_overrun got=%b exp=0", ifa.Overrun); end
    adv_a();
  endtask

  task automatic test_sc_held();
    step_a(0, 0, 0); adv_a();
    for (int i = 0; i < 12; i++) begin
      step_a(0, 1, 1);
      checks++; if (obs_a() !== exp_a()) begin failures++; $display("FAIL held_vec cyc=%0d got=%h exp=%h", i, obs_a(), exp_a()); end
      checks++; if (ifa.Inst_Count !== 16'(i / 3)) begin failures++; $display("FAIL held_icount cyc=%0d got=%0d exp=%0d", i, ifa.Inst_Count, i / 3); end
      adv_a();
    end
  endtask

  task automatic test_stall();
    step_a(0, 0, 0); adv_a();
    step_a(0, 0, 1); adv_a();
    for (int i = 0; i < 3; i++) begin
      step_a(1, 0, 1);
      checks++; if (ifa.TCount !== 4'd1) begin failures++; $display("FAIL stall_hold cyc=%0d got=%0d exp=1", i, ifa.TCount); end
      checks++; if ({ifa.Mem_Read, ifa.IR_Load, ifa.PC_Inc, ifa.Fetch} !== 4'b0001) begin
        failures++; $display("FAIL stall_strobes cyc=%0d got=%b exp=0001", i, {ifa.Mem_Read, ifa.IR_Load, ifa.PC_Inc, ifa.Fetch}); end
      checks++; if (obs_a() !== exp_a()) begin failures++; $display("FAIL stall_vec cyc=%0d got=%h exp=%h", i, obs_a(), exp_a()); end
      adv_a();
    end
    step_a(0, 0, 1);
    checks++; if ({ifa.Mem_Read, ifa.IR_Beat} !== 3'b101) begin failures++; $display("FAIL stall_release got=%b exp=101", {ifa.Mem_Read, ifa.IR_Beat}); end
    adv_a();
    step_a(0, 0, 1);
    checks++; if (obs_a() !== exp_a()) begin failures++; $display("FAIL stall_t2 got=%h exp=%h", obs_a(), exp_a()); end
    adv_a();
    step_a(1, 1, 1); adv_a();
    step_a(0, 0, 1);
    checks++; if (ifa.TCount !== 4'd3) begin failures++; $display("FAIL stall_sc_lost got=%0d exp=3", ifa.TCount); end
    checks++; if (ifa.Inst_Count !== 16'd0) begin failures++; $display("FAIL stall_sc_icount got=%0d exp=0", ifa.Inst_Count); end
    adv_a();
  endtask

  task automatic test_reset_mid();
    step_a(0, 0, 0); adv_a();
    for (int i = 0; i < 33; i++) begin
      step_a(0, (i < 21) && ((i % 3) == 2), 1);
      checks++; if (obs_a() !== exp_a()) begin failures++; $display("FAIL mid_vec cyc=%0d got=%h exp=%h", i, obs_a(), exp_a()); end
      adv_a();
    end
    step_a(0, 0, 0);
    checks++; if ({ifa.TCount, ifa.Overrun, ifa.Inst_Count} !== {4'd4, 1'b1, 16'd7}) begin
      failures++; $display("FAIL mid_before got=%0d/%b/%0d exp=4/1/7", ifa.TCount, ifa.Overrun, ifa.Inst_Count); end
    adv_a();
    step_a(0, 0, 1);
    checks++; if ({ifa.TCount, ifa.Overrun, ifa.Inst_Count, ifa.Mem_Read} !== {4'd0, 1'b0, 16'd0, 1'b1}) begin
      failures++; $display("FAIL mid_after got=%0d/%b/%0d/%b exp=0/0/0/1", ifa.TCount, ifa.Overrun, ifa.Inst_Count, ifa.Mem_Read); end
    adv_a();
  endtask

  task automatic test_random_a();
    step_a(0, 0, 0); adv_a();
    for (int i = 0; i < 400; i++) begin
      step_a(($urandom % 5) == 0, $urandom % 2, ($urandom % 50) != 0);
      checks++; if (obs_a() !== exp_a()) begin failures++; $display("FAIL rand_a_vec cyc=%0d got=%h exp=%h", i, obs_a(), exp_a()); end
      checks++; if (!$onehot(ifa.Timing)) begin failures++; $display("FAIL rand_a_onehot cyc=%0d got=%h", i, ifa.Timing); end
      adv_a();
    end
  endtask

  task automatic test_wrap_b();
    step_b(0, 0, 0); adv_b();
    for (int i = 0; i < 18; i++) begin
      step_b(0, (i % 2) == 1, 1);
      checks++; if (obs_b() !== exp_b()) begin failures++; $display("FAIL wrap_vec cyc=%0d got=%h exp=%h", i, obs_b(), exp_b()); end
      checks++; if (ifb.IR_Beat !== 2'd0) begin failures++; $display("FAIL wrap_beat cyc=%0d got=%0d exp=0", i, ifb.IR_Beat); end
      if (i == 14) begin
        checks++; if (ifb.Inst_Count !== 3'd7) begin failures++; $display("FAIL wrap_seven got=%0d exp=7", ifb.Inst_Count); end
      end
      if (i == 16) begin
        checks++; if (ifb.Inst_Count !== 3'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", ifb.Inst_Count); end
      end
      adv_b();
    end
    step_b(0, 0, 1);
    checks++; if (ifb.Inst_Count !== 3'd1) begin failures++; $display("FAIL wrap_one got=%0d exp=1", ifb.Inst_Count); end
    adv_b();
  endtask

  task automatic test_random_b();
    step_b(0, 0, 0); adv_b();
    for (int i = 0; i < 300; i++) begin
      step_b(($urandom % 6) == 0, ($urandom % 3) != 0, ($urandom % 60) != 0);
      checks++; if (obs_b() !== exp_b()) begin failures++; $display("FAIL rand_b_vec cyc=%0d got=%h exp=%h", i, obs_b(), exp_b()); end
      adv_b();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.Stall = 1'b0; ifa.SC_Clear = 1'b0;
    ifb.Stall = 1'b0; ifb.SC_Clear = 1'b0;
    ma_t = 0; ma_cnt = 0; ma_ov = 0; mb_t = 0; mb_cnt = 0; mb_ov = 0;
    sa_st = 0; sa_sc = 0; sa_rn = 0; sb_st = 0; sb_sc = 0; sb_rn = 0;
    test_reset();
    test_free_run();
    test_sc_pulse();
    test_sc_held();
    test_stall();
    test_reset_mid();
    test_random_a();
    test_wrap_b();
    test_random_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_timing_unit.md
Name: fetch_timing_unit

Overview:
- Parametrised successor to the fixed 4-bit timing-signal generator inside the control unit.
- Generates T-state timing for the multi-cycle CPU: one-hot T-state vector, plus fetch-phase strobes for a multi-beat instruction fetch from the 8-bit memory into the IR (byte-lane select, PC increment).
- Execute states are then held until the decoder signals end-of-instruction.
- Adds stall, overrun detection and a retired-instruction counter.

Parameters:
- T_STATES, 8: number of timing states; legal range FETCH_BEATS+1 .. 16.
- FETCH_BEATS, 2: memory beats per instruction fetch (2 = 16-bit IR from 8-bit memory); legal range 1..4.
- TW, 4: width of the binary T-state count; must satisfy 2^TW >= T_STATES.
- BW, 2: width of the byte-lane select; must satisfy 2^BW >= FETCH_BEATS.
- ICW, 16: width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Stall  in  1  hold current T-state; all strobes forced low.
- SC_Clear  in  1  end-of-instruction request from decoder.
- Timing  out  T_STATES  one-hot current T-state (bit k = Tk).
- TCount  out  TW  binary current T-state.
- Fetch  out  1  current state is a fetch beat.
- Exec  out  1  current state is an execute state.
- Mem_Read  out  1  memory read strobe for the fetch beat.
- IR_Load  out  1  IR load enable.
- IR_Beat  out  BW  IR byte lane to load (0 = low byte).
- PC_Inc  out  1  PC increment strobe.
- Overrun  out  1  sticky error: last T-state reached without SC_Clear.
- Inst_Count  out  ICW  retired-instruction count.

Behaviour:
- Reset is synchronous, active-low, and sampled on the Clock rising edge.
  - Reset values: TCount=0, Timing=1 (T0), Overrun=0, Inst_Count=0.
  - Strobes then follow combinational decode of T0, i.e. a fetch beat starts on the first cycle after reset release.
  - Reset mid-instruction abandons the instruction: no Inst_Count increment.
- TCount, Overrun and Inst_Count are registered. Timing is the registered one-hot of TCount and must always be one-hot.
- Strobes are combinational decode of the current TCount, gated by ~Stall:
  - Fetch = (TCount < FETCH_BEATS).
  - Exec = ~Fetch. Fetch and Exec are not gated by Stall; they reflect the state.
  - Mem_Read = IR_Load = PC_Inc = Fetch & ~Stall.
  - IR_Beat = TCount[BW-1:0] during fetch; 0 otherwise.
- Next-state priority: Reset > Stall > SC_Clear > advance.
  - Stall=1: TCount, Overrun and Inst_Count hold.
  - Fetch state: SC_Clear is ignored; TCount advances by 1. The fetch sequence always completes.
  - Exec state with SC_Clear=1: TCount goes to 0 and Inst_Count increments. Inst_Count wraps from all-ones to 0 and does not saturate.
  - Exec state, SC_Clear=0, TCount < T_STATES-1: TCount advances by 1.
  - Exec state, SC_Clear=0, TCount = T_STATES-1: TCount wraps to 0, Overrun is set, Inst_Count does not increment.
- SC_Clear together with Stall is lost: it is not queued, and the decoder must hold it.
- Overrun is cleared only by Reset.
- Latency:
  - One instruction with an E-cycle execute phase takes FETCH_BEATS+E cycles, SC_Clear asserted in the final execute cycle.
  - Minimum instruction length is FETCH_BEATS+1 cycles.
- Illegal parameter combinations stop elaboration via a generate-time check.

Test Plan:
- Reset then free run, defaults, SC_Clear held 0:
  - Timing sequence is 1,2,4,...,128, then back to 1.
  - Mem_Read/PC_Inc high only at T0,T1; IR_Beat 0 then 1.
  - Overrun rises on the cycle TCount returns 0 and stays high; Inst_Count stays 0.
- SC_Clear pulsed at T2 of each instruction, 5 instructions:
  - Period is 3 cycles; Inst_Count = 5; Overrun = 0.
- SC_Clear held high continuously:
  - Ignored at T0,T1; clears at T2.
  - Inst_Count increments once every 3 cycles.
- Stall asserted for 3 cycles at T1:
  - TCount holds 1; Mem_Read, IR_Load, PC_Inc = 0 during the stall; Fetch = 1.
  - After release, T1 strobes fire once with IR_Beat=1.
  - Stall+SC_Clear at T3: no clear, TCount stays 3.
- Reset=0 asserted at T4 with Inst_Count=7 and Overrun=1:
  - Next cycle TCount=0, Inst_Count=0, Overrun=0, Mem_Read=1.
- Rebuild with T_STATES=4, FETCH_BEATS=1, ICW=3; run 9 instructions with SC_Clear at T1:
  - Inst_Count wraps 7 → 0 → 1.
  - IR_Beat always 0.
